// File: rtl/argmax_pkg.sv
// Shared definitions for the sequential argmax/argmin search:
// FSM state encoding, search-mode constants and a constant-evaluable clog2.
package argmax_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

  // Ceiling log2, usable in parameter expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/argmax_extreme_cmp.sv
// Single comparator deciding whether candidate a should replace the current
// best b. Strict comparison, so on a tie the earlier (lower-index) best stays.
module extreme_cmp
  import argmax_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             a_better
);

  logic a_gt_b;
  logic a_lt_b;

  // Interpretation of the operands is fixed at elaboration time.
  if (SIGNED != 0) begin : g_signed
    assign a_gt_b = $signed(a) > $signed(b);
    assign a_lt_b = $signed(a) < $signed(b);
  end else begin : g_unsigned
    assign a_gt_b = a > b;
    assign a_lt_b = a < b;
  end

  assign a_better = (mode == MODE_MIN) ? a_lt_b : a_gt_b;

endmodule

// File: rtl/argmax_seq_n.sv
// Sequential argmax/argmin over N captured elements using one comparator.
// A start in IDLE snapshots X and mode, then one element is compared per
// clock; results are published on entry to DONE together with a done pulse.
module argmax_seq_n
  import argmax_pkg::*;
#(
  parameter  int WIDTH  = 5,
  parameter  int N      = 8,
  parameter  int SIGNED = 0,
  localparam int IDX_W  = (clog2(N) >= 1) ? clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_signal,
  input  logic                 mode,
  input  logic [N*WIDTH-1:0]   X,
  output logic [WIDTH-1:0]     output_extreme_number,
  output logic [IDX_W-1:0]     output_index,
  output logic                 busy,
  output logic                 done
);

  // The counter must be able to address element N-1.
  localparam int                CNT_W = (clog2(N + 1) >= 1) ? clog2(N + 1) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(N - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N*WIDTH-1:0] x_q, x_d;
  logic               mode_q, mode_d;
  logic [WIDTH-1:0]   best_q, best_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic [WIDTH-1:0]   res_val_q, res_val_d;
  logic [IDX_W-1:0]   res_idx_q, res_idx_d;

  logic [IDX_W-1:0]   cur_idx;
  logic [WIDTH-1:0]   cur_elem;
  logic               cur_better;

  // Select the captured element addressed by the counter.
  always_comb begin
    cur_idx  = cnt_q[IDX_W-1:0];
    cur_elem = x_q[int'(cur_idx) * WIDTH +: WIDTH];
  end

  extreme_cmp #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_cmp (
    .a        (cur_elem),
    .b        (best_q),
    .mode     (mode_q),
    .a_better (cur_better)
  );

  // Next-state logic of the IDLE -> COMPARE -> DONE sequence.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_signal) begin
          state_d = (N == 1) ? ST_DONE : ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture, compare-and-replace, and result publication on entry to DONE.
  always_comb begin
    cnt_d      = cnt_q;
    x_d        = x_q;
    mode_d     = mode_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    res_val_d  = res_val_q;
    res_idx_d  = res_idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_signal) begin
          x_d        = X;
          mode_d     = mode;
          best_d     = X[WIDTH-1:0];
          best_idx_d = '0;
          cnt_d      = CNT_W'(1);
        end
      end
      ST_COMPARE: begin
        cnt_d = cnt_q + 1'b1;
        if (cur_better) begin
          best_d     = cur_elem;
          best_idx_d = cur_idx;
        end
      end
      ST_DONE: cnt_d = '0;
      default: cnt_d = '0;
    endcase

    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      res_val_d = best_d;
      res_idx_d = best_idx_d;
    end
  end

  // Control and result registers; synchronous reset overrides any start.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      res_val_q <= '0;
      res_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      res_val_q <= res_val_d;
      res_idx_q <= res_idx_d;
    end
  end

  // Search working registers.
  always_ff @(posedge clk) begin
    // NOTE: the captured elements and running best are deliberately not
    // reset: they are always loaded at E0 before being read, and leaving
    // the wide snapshot reset-free keeps reset fan-out off the datapath.
    x_q        <= x_d;
    mode_q     <= mode_d;
    best_q     <= best_d;
    best_idx_q <= best_idx_d;
  end

  // Status and result outputs decoded from the state register.
  always_comb begin
    busy                  = (state_q == ST_COMPARE) || (state_q == ST_DONE);
    done                  = (state_q == ST_DONE);
    output_extreme_number = res_val_q;
    output_index          = res_idx_q;
  end

endmodule
